// File: rtl/draw_sequencer.sv
// Control FSM and request FIFO feeding the 4x4 block-drawing datapath.
// Serialises block draws and screen clears, with pending clears taking priority.
module draw_sequencer #(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] CLEAR_LAST = 16'd10239
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_x,
    input  logic [8:0]  req_y,
    input  logic [5:0]  req_colour,
    input  logic        clear_req,
    input  logic [4:0]  counter,
    input  logic [15:0] clear_counter,
    output logic [8:0]  x_input,
    output logic [8:0]  y_input,
    output logic [5:0]  colour_input,
    output logic        ld_block,
    output logic        ld_black,
    output logic        reset_counter,
    output logic        enable_counter,
    output logic        enable_clear_counter,
    output logic        plot,
    output logic        busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAW,
        CLR_LOAD,
        CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        mem_q [DEPTH];
    logic [23:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               clear_pending_q, clear_pending_d;
    logic               plot_q, plot_d;
    logic               push, pop, fifo_empty;

    // No bypass: a full FIFO refuses even when the head is popped this cycle.
    assign req_ready  = !reset && (count_q < FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign push       = req_valid && req_ready;
    assign pop        = (state_q == LOAD);

    assign {x_input, y_input, colour_input} = mem_q[rd_ptr_q];

    assign plot = plot_q;
    assign busy = (state_q != IDLE) || !fifo_empty || clear_pending_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {req_x, req_y, req_colour};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d              = state_q;
        ld_block             = 1'b0;
        ld_black             = 1'b0;
        reset_counter        = 1'b0;
        enable_counter       = 1'b0;
        enable_clear_counter = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_pending_q) begin
                    state_d = CLR_LOAD;
                end else if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_block      = 1'b1;
                reset_counter = 1'b1;
                state_d       = DRAW;
            end
            DRAW: begin
                enable_counter = 1'b1;
                if (counter == 5'd15) begin
                    state_d = IDLE;
                end
            end
            CLR_LOAD: begin
                ld_black      = 1'b1;
                reset_counter = 1'b1;
                state_d       = CLEAR;
            end
            CLEAR: begin
                enable_clear_counter = 1'b1;
                if (clear_counter == CLEAR_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            ld_block             = 1'b0;
            ld_black             = 1'b0;
            reset_counter        = 1'b0;
            enable_counter       = 1'b0;
            enable_clear_counter = 1'b0;
        end
    end

    // Entering CLR_LOAD consumes every clear requested so far, including one arriving that cycle.
    always_comb begin
        clear_pending_d = clear_pending_q || clear_req;
        if (state_q == IDLE && state_d == CLR_LOAD) begin
            clear_pending_d = 1'b0;
        end
        plot_d = enable_counter || enable_clear_counter;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            clear_pending_q <= 1'b0;
            plot_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            clear_pending_q <= clear_pending_d;
            plot_q          <= plot_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: a small datapath counter model plus
// hand-written per-cycle schedules of expected strobe activity.
module tb_draw_sequencer;

    localparam logic [15:0] CLEAR_LAST = 16'd10239;
    localparam byte unsigned S_IDLE  = 8'd0;
    localparam byte unsigned S_LOAD  = 8'd1;
    localparam byte unsigned S_DRAW  = 8'd2;
    localparam byte unsigned S_CLRLD = 8'd3;
    localparam byte unsigned S_CLEAR = 8'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_x = '0;
    logic [8:0]  req_y = '0;
    logic [5:0]  req_colour = '0;
    logic        clear_req = 1'b0;
    logic [4:0]  counter = '0;
    logic [15:0] clear_counter = '0;
    logic [8:0]  x_input;
    logic [8:0]  y_input;
    logic [5:0]  colour_input;
    logic        ld_block, ld_black, reset_counter;
    logic        enable_counter, enable_clear_counter;
    logic        plot, busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int idx;
        bit is_busy;
        bit val;
    } probe_t;

    byte unsigned sched_q[$];
    logic [23:0]  exp_blocks[$];
    logic [23:0]  push_q[$];
    int           clear_at[$];
    int           accept_idx[$];
    probe_t       probes[$];

    draw_sequencer #(
        .DEPTH(4),
        .CLEAR_LAST(CLEAR_LAST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x(req_x),
        .req_y(req_y),
        .req_colour(req_colour),
        .clear_req(clear_req),
        .counter(counter),
        .clear_counter(clear_counter),
        .x_input(x_input),
        .y_input(y_input),
        .colour_input(colour_input),
        .ld_block(ld_block),
        .ld_black(ld_black),
        .reset_counter(reset_counter),
        .enable_counter(enable_counter),
        .enable_clear_counter(enable_clear_counter),
        .plot(plot),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath counters: cleared by reset_counter, stepped by the enables.
    always @(posedge clk) begin
        if (reset_counter) begin
            counter       <= '0;
            clear_counter <= '0;
        end else begin
            if (enable_counter) counter <= counter + 5'd1;
            if (enable_clear_counter) clear_counter <= clear_counter + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic do_push, input logic [8:0] x, input logic [8:0] y,
                                 input logic [5:0] c, input logic do_clear);
        req_valid  = do_push;
        req_x      = x;
        req_y      = y;
        req_colour = c;
        clear_req  = do_clear;
        tick();
        req_valid  = 1'b0;
        clear_req  = 1'b0;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) sched_q.push_back(S_IDLE);
    endtask

    task automatic add_block(input logic [8:0] x, input logic [8:0] y, input logic [5:0] c);
        sched_q.push_back(S_LOAD);
        for (int i = 0; i < 16; i++) sched_q.push_back(S_DRAW);
        exp_blocks.push_back({x, y, c});
    endtask

    task automatic add_clear();
        sched_q.push_back(S_CLRLD);
        for (int i = 0; i <= int'(CLEAR_LAST); i++) sched_q.push_back(S_CLEAR);
    endtask

    task automatic add_probe(input int idx, input bit is_busy, input bit val);
        probe_t p;
        p.idx = idx;
        p.is_busy = is_busy;
        p.val = val;
        probes.push_back(p);
    endtask

    // Walks the expected schedule one cycle at a time, driving queued pushes and clear pulses.
    task automatic run_schedule(input string tag, input int push_from);
        logic        prev_en = 1'b0;
        logic        take;
        logic [5:0]  exp_vec;
        logic [23:0] head;
        byte unsigned code;
        int          fail_start = miscompares;
        for (int i = 0; i < sched_q.size(); i++) begin
            clear_req = 1'b0;
            foreach (clear_at[k]) if (clear_at[k] == i) clear_req = 1'b1;
            take = 1'b0;
            if (push_q.size() > 0 && i >= push_from) begin
                req_valid = 1'b1;
                {req_x, req_y, req_colour} = push_q[0];
                take = req_ready;
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (take) begin
                void'(push_q.pop_front());
                accept_idx.push_back(i);
            end
            code = sched_q[i];
            case (code)
                S_LOAD:  exp_vec = 6'b101000;
                S_DRAW:  exp_vec = 6'b000100;
                S_CLRLD: exp_vec = 6'b011000;
                S_CLEAR: exp_vec = 6'b000010;
                default: exp_vec = 6'b000000;
            endcase
            exp_vec[0] = prev_en;
            checkOutput($sformatf("%s strobes@%0d", tag, i),
                        32'({ld_block, ld_black, reset_counter, enable_counter, enable_clear_counter, plot}),
                        32'(exp_vec));
            if (code == S_LOAD) begin
                head = (exp_blocks.size() > 0) ? exp_blocks.pop_front() : 24'hFFFFFF;
                checkOutput($sformatf("%s head@%0d", tag, i), 32'({x_input, y_input, colour_input}), 32'(head));
            end
            foreach (probes[k]) begin
                if (probes[k].idx == i) begin
                    if (probes[k].is_busy)
                        checkOutput($sformatf("%s busy@%0d", tag, i), 32'(busy), 32'(probes[k].val));
                    else
                        checkOutput($sformatf("%s ready@%0d", tag, i), 32'(req_ready), 32'(probes[k].val));
                end
            end
            prev_en = (code == S_DRAW) || (code == S_CLEAR);
            if (miscompares - fail_start > 20) break;
        end
        req_valid = 1'b0;
        clear_req = 1'b0;
        sched_q.delete();
        exp_blocks.delete();
        push_q.delete();
        clear_at.delete();
        probes.delete();
    endtask

    initial begin
        int exp_acc[5];
        exp_acc = '{0, 1, 2, 3, 20};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("reset strobes",
                    32'({ld_block, ld_black, reset_counter, enable_counter, enable_clear_counter, plot}), 32'(0));
        checkOutput("reset busy", 32'(busy), 32'(0));
        reset = 1'b0;
        #1;
        checkOutput("post-reset ready", 32'(req_ready), 32'(1));

        // Single block
        applyStimulus(1'b1, 9'd40, 9'd20, 6'h3F, 1'b0);
        checkOutput("t1 busy after push", 32'(busy), 32'(1));
        checkOutput("t1 idle before load", 32'(ld_block), 32'(0));
        add_block(9'd40, 9'd20, 6'h3F);
        add_idle(2);
        add_probe(0, 1'b0, 1'b1);
        add_probe(8, 1'b0, 1'b1);
        add_probe(17, 1'b0, 1'b1);
        add_probe(16, 1'b1, 1'b1);
        add_probe(18, 1'b1, 1'b0);
        run_schedule("t1", 0);

        // FIFO fill and back-pressure: A pushed, then B..F offered back to back
        applyStimulus(1'b1, 9'd1, 9'd2, 6'h01, 1'b0);
        push_q = '{{9'd3, 9'd4, 6'h02}, {9'd5, 9'd6, 6'h03}, {9'd7, 9'd8, 6'h04},
                   {9'd9, 9'd10, 6'h05}, {9'd11, 9'd12, 6'h06}};
        add_block(9'd1, 9'd2, 6'h01);   add_idle(1);
        add_block(9'd3, 9'd4, 6'h02);   add_idle(1);
        add_block(9'd5, 9'd6, 6'h03);   add_idle(1);
        add_block(9'd7, 9'd8, 6'h04);   add_idle(1);
        add_block(9'd9, 9'd10, 6'h05);  add_idle(1);
        add_block(9'd11, 9'd12, 6'h06); add_idle(2);
        add_probe(3, 1'b0, 1'b0);
        add_probe(19, 1'b0, 1'b1);
        add_probe(20, 1'b0, 1'b0);
        add_probe(108, 1'b1, 1'b0);
        accept_idx.delete();
        run_schedule("t2", 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t2 accept%0d", i),
                        (accept_idx.size() > i) ? 32'(accept_idx[i]) : 32'hFFFFFFFF, 32'(exp_acc[i]));
        end

        // Clear has priority over two queued blocks
        applyStimulus(1'b1, 9'd100, 9'd200, 6'h15, 1'b1);
        push_q = '{{9'd101, 9'd201, 6'h2A}};
        add_clear();                       add_idle(1);
        add_block(9'd100, 9'd200, 6'h15);  add_idle(1);
        add_block(9'd101, 9'd201, 6'h2A);  add_idle(2);
        add_probe(0, 1'b1, 1'b1);
        run_schedule("t3", 0);

        // Clear during DRAW waits for the current block, then runs before the queued one
        applyStimulus(1'b1, 9'd300, 9'd7, 6'h0C, 1'b0);
        push_q = '{{9'd301, 9'd8, 6'h30}};
        clear_at = '{5};
        add_block(9'd300, 9'd7, 6'h0C);  add_idle(1);
        add_clear();                     add_idle(1);
        add_block(9'd301, 9'd8, 6'h30);  add_idle(2);
        run_schedule("t4", 0);

        // Two pulses merge into one pass; a pulse during CLEAR adds exactly one more
        applyStimulus(1'b1, 9'd511, 9'd511, 6'h00, 1'b0);
        clear_at = '{3, 6, 200};
        add_block(9'd511, 9'd511, 6'h00); add_idle(1);
        add_clear();                      add_idle(1);
        add_clear();                      add_idle(2);
        add_probe(20502, 1'b1, 1'b0);
        run_schedule("t5", 0);

        // Reset at DRAW step 7 with three requests queued
        applyStimulus(1'b1, 9'd50, 9'd60, 6'h11, 1'b0);
        push_q = '{{9'd51, 9'd61, 6'h12}, {9'd52, 9'd62, 6'h13}, {9'd53, 9'd63, 6'h14}};
        sched_q.push_back(S_LOAD);
        for (int i = 0; i < 8; i++) sched_q.push_back(S_DRAW);
        exp_blocks.push_back({9'd50, 9'd60, 6'h11});
        run_schedule("t6", 0);
        checkOutput("t6 counter before reset", 32'(counter), 32'(7));
        reset = 1'b1;
        tick();
        checkOutput("t6 strobes in reset",
                    32'({ld_block, ld_black, reset_counter, enable_counter, enable_clear_counter, plot}), 32'(0));
        checkOutput("t6 busy in reset", 32'(busy), 32'(0));
        reset = 1'b0;
        #1;
        checkOutput("t6 ready after reset", 32'(req_ready), 32'(1));
        add_idle(4);
        add_probe(3, 1'b1, 1'b0);
        run_schedule("t6 post", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
